regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
// - Write-side companion to the register-file read path. Collects writeback
//   requests from the ALU and load paths and buffers them in a small FIFO.
// - Drains one request per cycle into the register-file write port
//   (regWrite/writeReg/writeData).
// - Optionally offers a bypass lookup so the read stage can see pending writes.
// PARAMETERS
// - DATA_WIDTH  64  width of writeback data (matches readData1/readData2)
// - ADDR_WIDTH  5   register index width (32 registers)
// - DEPTH       4   pending-write FIFO entries; power of two, >= 2
// PORTS
// - clock      in   1           single clock, rising edge
// - reset      in   1           asynchronous, active-high
// - aluValid   in   1           ALU writeback request valid
// - aluReady   out  1           ALU request accepted this cycle
// - aluRd      in   ADDR_WIDTH  ALU destination register
// - aluData    in   DATA_WIDTH  ALU result
// - memValid   in   1           load writeback request valid
// - memReady   out  1           load request accepted this cycle
// - memRd      in   ADDR_WIDTH  load destination register
// - memData    in   DATA_WIDTH  load data
// - wbStall    in   1           hold the drain; FIFO keeps its contents
// - regWrite   out  1           register-file write enable
// - writeReg   out  ADDR_WIDTH  register-file write index
// - writeData  out  DATA_WIDTH  register-file write data
// - rs1Addr    in   ADDR_WIDTH  read-stage source 1 index (bypass lookup)
// - rs2Addr    in   ADDR_WIDTH  read-stage source 2 index (bypass lookup)
// - fwdHit1    out  1           a pending write targets rs1Addr
// - fwdData1   out  DATA_WIDTH  data of the youngest pending write to rs1Addr
// - fwdHit2    out  1           a pending write targets rs2Addr
// - fwdData2   out  DATA_WIDTH  data of the youngest pending write to rs2Addr
// - count      out  clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
// - Reset (async): pointers, count and all entries are cleared.
//   All outputs read 0 while reset is high and immediately after it falls.
// - Handshake: a transfer happens when valid && ready on a rising edge.
//   - memReady = !full.
//   - aluReady = !full && !memValid (the load path has priority).
//   - At most one enqueue per cycle. The losing ALU request must hold its
//     valid and payload until accepted.
// - Register x0: a request with rd==0 completes its handshake but is
//   discarded. It is not enqueued and never asserts regWrite.
// - Drain is combinational from the head entry:
//   - regWrite = !empty && !wbStall; writeReg/writeData = head entry.
//   - The head is popped on each edge where regWrite is 1.
//   - writeReg/writeData read 0 when empty.
// - Latency: a request accepted at edge N appears on the write port after
//   edge N (one cycle), provided the FIFO was empty and wbStall is low.
// - Enqueue and pop on the same edge: count is unchanged and both are
//   performed. Full blocks enqueue even when a pop occurs on the same edge.
// - Order is strict FIFO. Read and write pointers wrap modulo DEPTH.
// - Reset asserted mid-operation: pending writes are dropped and never
//   reach the register file.
// CONFIGURATION
// - FORWARD_EN defined:
//   - fwdHitN = 1 if any occupied entry has rd == rsNAddr and rsNAddr != 0.
//   - fwdDataN = data of the youngest such entry; 0 on a miss.
//   - The lookup is combinational, covers only buffered entries, and is
//     unaffected by wbStall.
// - FORWARD_EN undefined: fwdHit1/2 and fwdData1/2 are tied to 0 and no
//   comparators are built.
// TESTING
// - Async reset mid-run: 3 entries pending, pulse reset between edges ->
//   count=0 and regWrite=0 at once; no further writes occur.
// - Priority: memValid (rd5, 0xAA) and aluValid (rd6, 0xBB) in the same
//   cycle -> aluReady=0. Write port shows rd5/0xAA, then rd6/0xBB on the
//   next cycle.
// - x0 discard: aluValid with aluRd=0, data 0x55 -> aluReady=1, count
//   stays 0, regWrite never asserts.
// - Full and stall: wbStall=1 and 4 enqueues (rd1..rd4) -> count=4,
//   memReady=aluReady=0. Release wbStall -> 4 consecutive writes rd1..rd4
//   in order, then regWrite=0.
// - Bypass (FORWARD_EN): enqueue rd7/0x11 then rd7/0x22 under wbStall,
//   rs1Addr=7 -> fwdHit1=1, fwdData1=0x22. rs2Addr=0 -> fwdHit2=0.
//   Without the macro, fwdHit1=0.
// - Wrap-around: 10 back-to-back load writes rd1..rd10 with data=rd*3 ->
//   written in order with matching data; count never exceeds 2.

Source files
------------

// File: rtl/regfile_writeback.sv
// Pending-write FIFO between ALU/load writeback and the register-file write port.
// Define FORWARD_EN to build the read-stage bypass lookup over buffered entries.
module regfile_writeback #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      aluValid,
    output logic                      aluReady,
    input  logic [ADDR_WIDTH-1:0]     aluRd,
    input  logic [DATA_WIDTH-1:0]     aluData,
    input  logic                      memValid,
    output logic                      memReady,
    input  logic [ADDR_WIDTH-1:0]     memRd,
    input  logic [DATA_WIDTH-1:0]     memData,
    input  logic                      wbStall,
    output logic                      regWrite,
    output logic [ADDR_WIDTH-1:0]     writeReg,
    output logic [DATA_WIDTH-1:0]     writeData,
    input  logic [ADDR_WIDTH-1:0]     rs1Addr,
    input  logic [ADDR_WIDTH-1:0]     rs2Addr,
    output logic                      fwdHit1,
    output logic [DATA_WIDTH-1:0]     fwdData1,
    output logic                      fwdHit2,
    output logic [DATA_WIDTH-1:0]     fwdData2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [CW-1:0]         cnt;

    logic                  full;
    logic                  empty;
    logic                  mem_fire;
    logic                  alu_fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] enq_rd;
    logic [DATA_WIDTH-1:0] enq_data;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Load path wins; the ALU only sees ready when no load is offered.
    assign memReady = !reset && !full;
    assign aluReady = !reset && !full && !memValid;

    assign mem_fire = memValid && memReady;
    assign alu_fire = aluValid && aluReady;

    always_comb begin
        enq_rd   = '0;
        enq_data = '0;
        if (mem_fire) begin
            enq_rd   = memRd;
            enq_data = memData;
        end else if (alu_fire) begin
            enq_rd   = aluRd;
            enq_data = aluData;
        end
    end

    // Writes to x0 finish the handshake but never occupy an entry.
    assign push = (mem_fire || alu_fire) && (enq_rd != '0);
    assign pop  = !empty && !wbStall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                rd_q[wptr]   <= enq_rd;
                data_q[wptr] <= enq_data;
                wptr         <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign regWrite  = pop;
    assign writeReg  = empty ? '0 : rd_q[rptr];
    assign writeData = empty ? '0 : data_q[rptr];
    assign count     = cnt;

`ifdef FORWARD_EN
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwdHit1  = 1'b0;
        fwdData1 = '0;
        fwdHit2  = 1'b0;
        fwdData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt) begin
                if (rs1Addr != '0 && rd_q[rptr + PW'(i)] == rs1Addr) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = data_q[rptr + PW'(i)];
                end
                if (rs2Addr != '0 && rd_q[rptr + PW'(i)] == rs2Addr) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = data_q[rptr + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{rs1Addr, rs2Addr};
    assign fwdHit1   = 1'b0;
    assign fwdData1  = '0;
    assign fwdHit2   = 1'b0;
    assign fwdData2  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: queue-level model, directed cases,
// then constrained-random traffic.
module tb_regfile_writeback;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          aluValid = 1'b0;
    logic          aluReady;
    logic [AW-1:0] aluRd = '0;
    logic [DW-1:0] aluData = '0;
    logic          memValid = 1'b0;
    logic          memReady;
    logic [AW-1:0] memRd = '0;
    logic [DW-1:0] memData = '0;
    logic          wbStall = 1'b0;
    logic          regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic [AW-1:0] rs1Addr = '0;
    logic [AW-1:0] rs2Addr = '0;
    logic          fwdHit1;
    logic [DW-1:0] fwdData1;
    logic          fwdHit2;
    logic [DW-1:0] fwdData2;
    logic [2:0]    count;

    int tests = 0;
    int failed = 0;

    ent_t pend[$];
    ent_t exp_q[$];
    bit   alu_acc = 1'b0;

    regfile_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData),
        .wbStall(wbStall),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .fwdHit1(fwdHit1), .fwdData1(fwdData1),
        .fwdHit2(fwdHit2), .fwdData2(fwdData2),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of pending writes, updated once per edge.
    int   m_n;
    bit   m_full, m_pop, m_mf, m_af;
    ent_t m_e;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend.delete();
            exp_q.delete();
            alu_acc = 1'b0;
        end else begin
            m_n    = pend.size();
            m_full = (m_n == DEPTH);
            m_pop  = (m_n > 0) && !wbStall;
            m_mf   = memValid && !m_full;
            m_af   = aluValid && !m_full && !memValid;
            alu_acc = m_af;
            if (m_pop) void'(pend.pop_front());
            m_e.rd = '0;
            m_e.data = '0;
            if (m_mf) begin
                m_e.rd = memRd;
                m_e.data = memData;
            end else if (m_af) begin
                m_e.rd = aluRd;
                m_e.data = aluData;
            end
            if ((m_mf || m_af) && m_e.rd != 0) begin
                pend.push_back(m_e);
                exp_q.push_back(m_e);
            end
        end
    end

    function automatic void fwd_exp(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d = '0;
`ifdef FORWARD_EN
        if (a != 0)
            foreach (pend[i])
                if (pend[i].rd == a) begin
                    hit = 1'b1;
                    d = pend[i].data;
                end
`endif
    endfunction

    // Monitor: checks every output against the model away from the clock edge.
    logic          e_hit;
    logic [DW-1:0] e_dat;
    ent_t          got;
    always @(negedge clock) begin
        if (!reset) begin
            chk("count", count, pend.size());
            chk("memReady", memReady, pend.size() < DEPTH);
            chk("aluReady", aluReady, (pend.size() < DEPTH) && !memValid);
            chk("regWrite", regWrite, (pend.size() > 0) && !wbStall);
            if (pend.size() == 0) begin
                chk("writeReg_empty", writeReg, 0);
                chk("writeData_empty", writeData, 0);
            end
            fwd_exp(rs1Addr, e_hit, e_dat);
            chk("fwdHit1", fwdHit1, e_hit);
            chk("fwdData1", fwdData1, e_dat);
            fwd_exp(rs2Addr, e_hit, e_dat);
            chk("fwdHit2", fwdHit2, e_hit);
            chk("fwdData2", fwdData2, e_dat);
            if (regWrite) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", writeReg, 0);
                    chk("unexpected_write_flag", regWrite, 0);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_rd", writeReg, got.rd);
                    chk("sb_data", writeData, got.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        memValid = 1'b0;
        aluValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pend.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 40, 1);
    endtask

    int maxc;

    initial begin
        // Outputs held at zero while reset is high.
        @(negedge clock);
        @(negedge clock);
        chk("rst_regWrite", regWrite, 0);
        chk("rst_count", count, 0);
        chk("rst_writeReg", writeReg, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_memReady", memReady, 0);
        chk("rst_aluReady", aluReady, 0);
        chk("rst_fwdHit1", fwdHit1, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_count", count, 0);
        chk("post_rst_regWrite", regWrite, 0);

        // Load wins over ALU; ALU holds and goes next.
        step();
        memValid = 1; memRd = 5; memData = 'hAA;
        aluValid = 1; aluRd = 6; aluData = 'hBB;
        @(negedge clock);
        chk("prio_aluReady", aluReady, 0);
        chk("prio_memReady", memReady, 1);
        step();
        memValid = 0;
        @(negedge clock);
        chk("prio_aluReady2", aluReady, 1);
        chk("prio_wr1_rd", writeReg, 5);
        chk("prio_wr1_data", writeData, 'hAA);
        step();
        idle();
        @(negedge clock);
        chk("prio_wr2_rd", writeReg, 6);
        chk("prio_wr2_data", writeData, 'hBB);
        drain();

        // x0 request accepted but dropped.
        step();
        aluValid = 1; aluRd = 0; aluData = 'h55;
        @(negedge clock);
        chk("x0_aluReady", aluReady, 1);
        step();
        idle();
        @(negedge clock);
        chk("x0_count", count, 0);
        chk("x0_regWrite", regWrite, 0);

        // Fill under stall, then release and drain in order.
        step();
        wbStall = 1;
        for (int r = 1; r <= 4; r++) begin
            memValid = 1; memRd = AW'(r); memData = DW'(r);
            step();
        end
        idle();
        aluValid = 1; aluRd = 9; aluData = 'h99;
        @(negedge clock);
        chk("full_count", count, 4);
        chk("full_memReady", memReady, 0);
        chk("full_aluReady", aluReady, 0);
        step();
        aluValid = 0;
        wbStall = 0;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clock);
            chk("full_drain_we", regWrite, 1);
            chk("full_drain_rd", writeReg, r);
        end
        @(negedge clock);
        chk("full_done_we", regWrite, 0);

        // Bypass lookup returns the youngest match.
        step();
        wbStall = 1;
        memValid = 1; memRd = 7; memData = 'h11;
        step();
        memData = 'h22;
        step();
        idle();
        rs1Addr = 7; rs2Addr = 0;
        @(negedge clock);
`ifdef FORWARD_EN
        chk("byp_hit1", fwdHit1, 1);
        chk("byp_data1", fwdData1, 'h22);
`else
        chk("byp_hit1", fwdHit1, 0);
        chk("byp_data1", fwdData1, 0);
`endif
        chk("byp_hit2", fwdHit2, 0);
        step();
        wbStall = 0;
        drain();
        rs1Addr = 0;

        // Back-to-back loads wrap the pointers.
        maxc = 0;
        for (int r = 1; r <= 10; r++) begin
            memValid = 1; memRd = AW'(r); memData = DW'(r * 3);
            @(negedge clock);
            if (int'(count) > maxc) maxc = int'(count);
            step();
        end
        idle();
        drain();
        chk("wrap_max_count", maxc <= 2, 1);

        // Reset between edges drops all pending writes.
        wbStall = 1;
        for (int r = 1; r <= 3; r++) begin
            memValid = 1; memRd = AW'(r + 10); memData = DW'(r);
            step();
        end
        idle();
        @(posedge clock);
        #2 reset = 1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_regWrite", regWrite, 0);
        #1 reset = 0;
        wbStall = 0;
        repeat (5) step();

        // Random traffic; a refused ALU request keeps its payload.
        for (int c = 0; c < 400; c++) begin
            memValid = ($urandom_range(0, 2) == 0);
            memRd = AW'($urandom_range(0, 7));
            memData = {$urandom, $urandom};
            if (!(aluValid && !alu_acc)) begin
                aluValid = ($urandom_range(0, 1) == 0);
                aluRd = AW'($urandom_range(0, 7));
                aluData = {$urandom, $urandom};
            end
            wbStall = ($urandom_range(0, 3) == 0);
            rs1Addr = AW'($urandom_range(0, 7));
            rs2Addr = AW'($urandom_range(0, 7));
            step();
        end
        idle();
        wbStall = 0;
        drain();
        step();
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
